inst_prefetch_buffer: RTL

//  Fetch stage upstream of the single-cycle core's decode/execute logic. Owns the fetch PC and

---
 rtl/inst_prefetch_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, issues reads to a
// synchronous instruction SRAM and queues returned words with their PCs
// for the decode stage over a valid/ready handshake. Branch redirects
// flush the queue and drop any read still in flight.
module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [AW:0]   count;
  logic [AW:0]   used;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  // Credit counts buffered plus in-flight words so a returning read always
  // has a free slot; a same-cycle pop deliberately does not free a credit.
  assign used  = count + (AW+1)'(inflight);
  assign issue = ~reset & ~br_taken & (used < DEPTH_C);
  assign push  = inflight & ~br_taken;
  assign pop   = if_valid & id_ready & ~br_taken;

  assign inst_sram_en    = issue;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = fpc;
  assign inst_sram_wdata = '0;

  assign if_valid = (count != '0);
  assign if_pc    = pc_mem[rd_ptr];
  assign if_inst  = inst_mem[rd_ptr];

  // Fetch PC and outstanding-request tracking; a redirect kills the read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc      <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (br_taken) begin
      fpc      <= {br_target[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fpc    <= fpc + 32'd4;
        req_pc <= fpc;
      end
    end
  end

  // FIFO pointers and occupancy; redirect flush has priority over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (br_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= inst_sram_rdata;
    end
  end

  // The credit rule makes a push into a full FIFO impossible.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (reset) push |-> (count < DEPTH_C)
  );

endmodule
